sonic_range_conv: RTL and testbench
===================================

# sonic_range_conv

Downstream consumer of the ultrasonic echo-width measurement. It takes each raw echo pulse width, counted in clock ticks, and converts it to whole centimetres with a sequential divider. It then clamps the value to the sensor's usable range, applies a median-of-3 glitch filter, and produces a 3-digit BCD value. Its outputs drive the board LEDs or a 7-segment display in place of raw tick counts.

## Interface
- `CW`, 24: width of the input echo count.
- `TICKS_PER_CM`, 2900: clock ticks per centimetre of range (round trip, 58 µs/cm at 50 MHz).
- `MAX_CM`, 400: largest valid distance; must be ≤ 999.
- `clock` input, 1: single system clock; all logic is on its rising edge.
- `reset` input, 1: synchronous, active-high.
- `echo_count` input, CW: echo high-time in ticks; sampled only when `echo_valid` is high.
- `echo_valid` input, 1: one-cycle strobe marking a new measurement.
- `busy` output, 1: high from the capture cycle until the `dist_valid` cycle, inclusive.
- `dist_cm` output, 10: filtered distance in binary centimetres.
- `dist_bcd` output, 12: `dist_cm` as BCD, hundreds in [11:8], tens in [7:4], ones in [3:0].
- `dist_valid` output, 1: one-cycle strobe; `dist_cm`, `dist_bcd` and `out_of_range` are updated on the same cycle.
- `out_of_range` output, 1: the current result was clamped, or the input was all ones (sensor timeout).
- `overrun` output, 1: sticky flag, set when `echo_valid` arrives while `busy` is high.

## Operation
- **State machine:** IDLE → DIV → CLAMP → FILT → BCD → DONE → IDLE.
- **IDLE:**
  - If `echo_valid` is high, latch `echo_count`, set `busy`, and go to DIV.
  - Otherwise stay in IDLE.
- **DIV:** restoring shift-subtract division of the latched count by `TICKS_PER_CM`.
  - Runs for exactly CW cycles, one quotient bit per cycle, MSB first.
  - Quotient = floor(count / TICKS_PER_CM); the remainder is discarded.
- **CLAMP (1 cycle):**
  - If quotient > `MAX_CM`, or the count was all ones: value = `MAX_CM` and the range flag is set.
  - Otherwise: value = quotient and the range flag is clear.
- **FILT (1 cycle):** the history is a 3-entry shift register h0/h1/h2.
  - The clamped value shifts in.
  - Result = median(h0, h1, h2).
  - The first sample after reset fills all three entries.
  - The range flag is not filtered; it always reflects the newest sample.
- **BCD:** double-dabble conversion of the 10-bit result.
  - Takes exactly 10 cycles, one per bit: add-3 to any digit ≥ 5, then shift.
- **DONE (1 cycle):**
  - Register `dist_cm`, `dist_bcd` and `out_of_range`.
  - Pulse `dist_valid`.
  - Return to IDLE with `busy` low on the next cycle.
- **Overrun:** `echo_valid` while not in IDLE is dropped. It sets `overrun`, which only `reset` clears.
- **Simultaneous events:** `echo_valid` in the same cycle as DONE is dropped and counts as an overrun. `echo_valid` is accepted only in IDLE.
- **Reset** (at any time, including mid-division):
  - State goes to IDLE.
  - `busy`, `dist_valid`, `out_of_range` and `overrun` go to 0.
  - `dist_cm` and `dist_bcd` go to 0.
  - The history is marked empty.

## Timing
- **Latency:** `echo_valid` sampled high at edge k gives `dist_valid` high during cycle k+CW+13, which is 37 cycles at the defaults.
- **Throughput:** one measurement per CW+14 cycles. This is far faster than the sensor's measurement interval.
- **Output stability:** `dist_cm`, `dist_bcd` and `out_of_range` hold their values between `dist_valid` pulses.
- **Registered outputs:** all outputs are registered; there is no combinational path from input to output.

## Structure
- **Shared header `sonic_defs.vh`** holds:
  - the state encodings;
  - the defaults for `CW`, `TICKS_PER_CM` and `MAX_CM`.
- **Sub-module `bin2bcd_seq`:** the 10-bit, 3-digit double-dabble converter with start/done handshake. It is reusable for other display paths.
- **Inline logic:** the divider and the median filter stay inline in `sonic_range_conv`.

## Test plan
- **Basic conversion:** reset, then count 29000 → `dist_cm`=10, `dist_bcd`=0x010, `out_of_range`=0; `dist_valid` exactly 37 cycles after the strobe.
- **Boundaries:**
  - count 2899 → 0 cm, BCD 0x000.
  - count 1,160,000 → 400, `out_of_range`=0.
  - count 1,162,900 → 400, `out_of_range`=1.
  - count 0xFFFFFF → 400, `out_of_range`=1.
- **Median filter:** after reset, feed 100, 300, 102 cm (290000, 870000, 295800) → outputs 100, 100, 102.
- **Overrun:**
  - Second `echo_valid` 5 cycles after the first → ignored, `overrun`=1, only one `dist_valid`.
  - Strobe on the DONE cycle → also dropped.
- **Reset mid-operation:** assert `reset` 10 cycles into DIV → no `dist_valid`, all outputs 0. A following count of 58000 → 20 cm, and the history is refilled by that sample.
- **BCD digits:** count 986,000 → 340 cm, `dist_bcd`=0x340.

Source files
------------

// File: rtl/sonic_range_conv_pkg.sv
// rtl/sonic_range_conv_pkg.sv - shared types, defaults and helpers for the range converter
//
// Holds the sequencer state encoding, the parameter defaults, the result
// widths and the small arithmetic helpers used by the converter and its
// BCD sub-module.
package sonic_range_conv_pkg;

    localparam int CW_DEFAULT           = 24;
    localparam int TICKS_PER_CM_DEFAULT = 2900;
    localparam int MAX_CM_DEFAULT       = 400;

    localparam int DIST_W = 10;
    localparam int BCD_W  = 12;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DIV   = 3'd1,
        S_CLAMP = 3'd2,
        S_FILT  = 3'd3,
        S_BCD   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Median of three: clip c into the [min(a,b), max(a,b)] window.
    function automatic logic [DIST_W-1:0] median3(input logic [DIST_W-1:0] a,
                                                  input logic [DIST_W-1:0] b,
                                                  input logic [DIST_W-1:0] c);
        logic [DIST_W-1:0] lo;
        logic [DIST_W-1:0] hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (c < lo)
            return lo;
        else if (c > hi)
            return hi;
        else
            return c;
    endfunction

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more,
    // so the following left shift carries correctly into the next digit.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] r;
        r = d;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (d[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = d[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/sonic_range_conv_bin2bcd_seq.sv
// rtl/sonic_range_conv_bin2bcd_seq.sv - sequential 10-bit to 3-digit BCD converter
//
// Module bin2bcd_seq: double-dabble converter, one input bit per cycle.
// The start cycle loads the operand and already performs the first shift,
// so a conversion occupies exactly 10 cycles; done pulses for one cycle
// once bcd holds the result, and bcd then holds until the next start.
//
// Ports:
//   clock  - system clock, rising edge
//   reset  - synchronous, active-high
//   start  - one-cycle request, samples bin
//   bin    - 10-bit binary operand (values up to 999 are representable)
//   done   - one-cycle pulse, result valid on bcd
//   bcd    - hundreds [11:8], tens [7:4], ones [3:0]
module bin2bcd_seq
    import sonic_range_conv_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DIST_W-1:0] bin,
    output logic              done,
    output logic [BCD_W-1:0]  bcd
);

    logic [DIST_W-1:0] bin_sr;
    logic [BCD_W-1:0]  bcd_sr;
    logic [3:0]        cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            bin_sr <= '0;
            bcd_sr <= '0;
            cnt    <= '0;
            done   <= 1'b0;
        end else if (start) begin
            // Adjusting an all-zero digit field is a no-op, so the first
            // iteration reduces to a plain shift of the fresh operand.
            {bcd_sr, bin_sr} <= {{BCD_W{1'b0}}, bin} << 1;
            cnt              <= 4'd9;
            done             <= 1'b0;
        end else if (cnt != 4'd0) begin
            {bcd_sr, bin_sr} <= {dd_adjust(bcd_sr), bin_sr} << 1;
            cnt              <= cnt - 4'd1;
            done             <= (cnt == 4'd1);
        end else begin
            done <= 1'b0;
        end
    end

    assign bcd = bcd_sr;

endmodule

// File: rtl/sonic_range_conv.sv
// rtl/sonic_range_conv.sv - echo tick count to filtered centimetres and BCD
//
// Converts a raw echo pulse width (clock ticks) into whole centimetres with
// a restoring divider, clamps to the usable range, median-of-3 filters the
// result and converts it to BCD for display.
//
// Ports:
//   clock        - system clock, rising edge
//   reset        - synchronous, active-high
//   echo_count   - echo high-time in ticks, sampled with echo_valid
//   echo_valid   - one-cycle strobe, accepted only while idle
//   busy         - high from capture until the dist_valid cycle inclusive
//   dist_cm      - filtered distance, binary centimetres
//   dist_bcd     - dist_cm as three BCD digits
//   dist_valid   - one-cycle strobe, outputs updated in the same cycle
//   out_of_range - newest sample was clamped or was a sensor timeout
//   overrun      - sticky, a strobe arrived while busy
module sonic_range_conv
    import sonic_range_conv_pkg::*;
#(
    parameter int CW           = CW_DEFAULT,
    parameter int TICKS_PER_CM = TICKS_PER_CM_DEFAULT,
    parameter int MAX_CM       = MAX_CM_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CW-1:0]     echo_count,
    input  logic              echo_valid,
    output logic              busy,
    output logic [DIST_W-1:0] dist_cm,
    output logic [BCD_W-1:0]  dist_bcd,
    output logic              dist_valid,
    output logic              out_of_range,
    output logic              overrun
);

    localparam int                CNT_W   = $clog2(CW) + 1;
    localparam int                CW1     = CW + 1;
    localparam logic [CW:0]       DIVISOR = CW1'(TICKS_PER_CM);
    localparam logic [DIST_W-1:0] MAX_VAL = DIST_W'(MAX_CM);

    state_t            state;
    state_t            state_next;

    // Divider: dq starts as the dividend and fills with quotient bits from
    // the LSB as dividend bits leave from the MSB.
    logic [CW-1:0]     rem;
    logic [CW-1:0]     dq;
    logic [CNT_W-1:0]  div_cnt;
    logic [CW:0]       trial;
    logic              trial_ge;
    logic              timeout;

    logic [DIST_W-1:0] clamp_val;
    logic              range_flag;
    logic [DIST_W-1:0] h0;
    logic [DIST_W-1:0] h1;
    logic [DIST_W-1:0] h2;
    logic              hist_full;
    logic [DIST_W-1:0] med;

    logic              bcd_start;
    logic              bcd_done;
    logic [BCD_W-1:0]  bcd_value;

    always_ff @(posedge clock) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (echo_valid) state_next = S_DIV;
            S_DIV:   if (div_cnt == CNT_W'(CW - 1)) state_next = S_CLAMP;
            S_CLAMP: state_next = S_FILT;
            S_FILT:  state_next = S_BCD;
            S_BCD:   if (bcd_done) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Both flags decode the state register only, so they stay registered.
    always_comb begin
        busy       = (state != S_IDLE);
        dist_valid = (state == S_DONE);
    end

    always_comb begin
        trial    = {rem, dq[CW-1]};
        trial_ge = (trial >= DIVISOR);
        // History is stable from the FILT edge until the result is taken,
        // so the median can feed both the converter and dist_cm directly.
        med      = median3(h0, h1, h2);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rem          <= '0;
            dq           <= '0;
            div_cnt      <= '0;
            timeout      <= 1'b0;
            clamp_val    <= '0;
            range_flag   <= 1'b0;
            h0           <= '0;
            h1           <= '0;
            h2           <= '0;
            hist_full    <= 1'b0;
            bcd_start    <= 1'b0;
            dist_cm      <= '0;
            dist_bcd     <= '0;
            out_of_range <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            bcd_start <= 1'b0;
            if (echo_valid && state != S_IDLE)
                overrun <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (echo_valid) begin
                        dq      <= echo_count;
                        rem     <= '0;
                        div_cnt <= '0;
                        timeout <= &echo_count;
                    end
                end
                S_DIV: begin
                    rem     <= trial_ge ? CW'(trial - DIVISOR) : trial[CW-1:0];
                    dq      <= {dq[CW-2:0], trial_ge};
                    div_cnt <= div_cnt + 1'b1;
                end
                S_CLAMP: begin
                    if (timeout || dq > CW'(MAX_CM)) begin
                        clamp_val  <= MAX_VAL;
                        range_flag <= 1'b1;
                    end else begin
                        clamp_val  <= dq[DIST_W-1:0];
                        range_flag <= 1'b0;
                    end
                end
                S_FILT: begin
                    // An empty history is seeded entirely with the first
                    // sample so the median starts out equal to it.
                    h0        <= clamp_val;
                    h1        <= hist_full ? h0 : clamp_val;
                    h2        <= hist_full ? h1 : clamp_val;
                    hist_full <= 1'b1;
                    bcd_start <= 1'b1;
                end
                S_BCD: begin
                    if (bcd_done) begin
                        dist_cm      <= med;
                        dist_bcd     <= bcd_value;
                        out_of_range <= range_flag;
                    end
                end
                default: ;
            endcase
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clock (clock),
        .reset (reset),
        .start (bcd_start),
        .bin   (med),
        .done  (bcd_done),
        .bcd   (bcd_value)
    );

endmodule

// File: tb/tb_sonic_range_conv.sv
// tb/tb_sonic_range_conv.sv - self-checking bench for sonic_range_conv
module tb_sonic_range_conv;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] echo_count = '0;
    logic        echo_valid = 1'b0;
    logic        busy;
    logic [9:0]  dist_cm;
    logic [11:0] dist_bcd;
    logic        dist_valid;
    logic        out_of_range;
    logic        overrun;

    int vectors = 0;
    int miscompares = 0;

    int hist[$];

    typedef struct {
        logic [23:0] count;
        int          cm;
        int          bcd;
        int          oor;
    } vec_t;

    vec_t tbl[7];

    sonic_range_conv dut (
        .clock        (clock),
        .reset        (reset),
        .echo_count   (echo_count),
        .echo_valid   (echo_valid),
        .busy         (busy),
        .dist_cm      (dist_cm),
        .dist_bcd     (dist_bcd),
        .dist_valid   (dist_valid),
        .out_of_range (out_of_range),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        echo_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        hist.delete();
    endtask

    // Reference: centimetres with clamp, then median over the last three.
    function automatic int to_bcd(input int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    task automatic model(input logic [23:0] c, output int cm, output int oor);
        int q;
        int a;
        int b;
        int m;
        q = int'(c) / 2900;
        if (c == 24'hFFFFFF || q > 400) begin
            m = 400;
            oor = 1;
        end else begin
            m = q;
            oor = 0;
        end
        if (hist.size() == 0) begin
            hist.push_back(m);
            hist.push_back(m);
            hist.push_back(m);
        end else begin
            hist.push_front(m);
            void'(hist.pop_back());
        end
        a = (hist[0] < hist[1]) ? hist[0] : hist[1];
        b = (hist[0] < hist[1]) ? hist[1] : hist[0];
        cm = (hist[2] < a) ? a : (hist[2] > b) ? b : hist[2];
    endtask

    task automatic measure(input logic [23:0] c, output int cm, output int bcd,
                           output int oor, output int lat);
        echo_count = c;
        echo_valid = 1'b1;
        @(posedge clock);
        #1;
        echo_valid = 1'b0;
        lat = 0;
        while (!dist_valid && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        cm  = int'(dist_cm);
        bcd = int'(dist_bcd);
        oor = int'(out_of_range);
        @(posedge clock);
        #1;
    endtask

    task automatic watch(input int n, output int pulses, output int last_cm);
        pulses = 0;
        last_cm = -1;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (dist_valid) begin
                pulses++;
                last_cm = int'(dist_cm);
            end
        end
    endtask

    initial begin
        int cm;
        int bcd;
        int oor;
        int lat;
        int pulses;
        int last;
        int ecm;
        int eoor;
        logic [23:0] c;

        tbl[0] = '{24'd29000,   10,  'h010, 0};
        tbl[1] = '{24'd2899,    0,   'h000, 0};
        tbl[2] = '{24'd1160000, 400, 'h400, 0};
        tbl[3] = '{24'd1162900, 400, 'h400, 1};
        tbl[4] = '{24'hFFFFFF,  400, 'h400, 1};
        tbl[5] = '{24'd986000,  340, 'h340, 0};
        tbl[6] = '{24'd58000,   20,  'h020, 0};

        do_reset();
        check("reset busy", int'(busy), 0);
        check("reset dist_valid", int'(dist_valid), 0);
        check("reset dist_cm", int'(dist_cm), 0);
        check("reset dist_bcd", int'(dist_bcd), 0);
        check("reset out_of_range", int'(out_of_range), 0);
        check("reset overrun", int'(overrun), 0);

        // Each table entry starts from an empty history, so the filter
        // passes the clamped value straight through.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            measure(tbl[i].count, cm, bcd, oor, lat);
            check($sformatf("tbl%0d latency", i), lat, 37);
            check($sformatf("tbl%0d dist_cm", i), cm, tbl[i].cm);
            check($sformatf("tbl%0d dist_bcd", i), bcd, tbl[i].bcd);
            check($sformatf("tbl%0d out_of_range", i), oor, tbl[i].oor);
            check($sformatf("tbl%0d busy after", i), int'(busy), 0);
        end

        // Median filter sequence.
        do_reset();
        measure(24'd290000, cm, bcd, oor, lat);
        check("median 1", cm, 100);
        measure(24'd870000, cm, bcd, oor, lat);
        check("median 2", cm, 100);
        measure(24'd295800, cm, bcd, oor, lat);
        check("median 3", cm, 102);
        check("median 3 bcd", bcd, 'h102);

        // Overrun: second strobe five cycles after the first.
        do_reset();
        echo_count = 24'd290000;
        echo_valid = 1'b1;
        @(posedge clock);
        #1;
        echo_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        echo_count = 24'd870000;
        echo_valid = 1'b1;
        @(posedge clock);
        #1;
        echo_valid = 1'b0;
        check("overrun set", int'(overrun), 1);
        watch(80, pulses, last);
        check("overrun pulses", pulses, 1);
        check("overrun dist_cm", last, 100);

        // Strobe during the DONE cycle is dropped.
        do_reset();
        echo_count = 24'd29000;
        echo_valid = 1'b1;
        @(posedge clock);
        #1;
        echo_valid = 1'b0;
        lat = 0;
        while (!dist_valid && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check("done strobe latency", lat, 37);
        check("done strobe overrun before", int'(overrun), 0);
        echo_count = 24'd58000;
        echo_valid = 1'b1;
        @(posedge clock);
        #1;
        echo_valid = 1'b0;
        check("done strobe overrun", int'(overrun), 1);
        check("done strobe busy", int'(busy), 0);
        watch(60, pulses, last);
        check("done strobe pulses", pulses, 0);
        check("done strobe held cm", int'(dist_cm), 10);

        // Reset in the middle of a division.
        do_reset();
        measure(24'd290000, cm, bcd, oor, lat);
        measure(24'd870000, cm, bcd, oor, lat);
        echo_count = 24'd986000;
        echo_valid = 1'b1;
        @(posedge clock);
        #1;
        echo_valid = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        do_reset();
        check("midreset busy", int'(busy), 0);
        check("midreset dist_cm", int'(dist_cm), 0);
        check("midreset dist_bcd", int'(dist_bcd), 0);
        check("midreset overrun", int'(overrun), 0);
        watch(50, pulses, last);
        check("midreset pulses", pulses, 0);
        measure(24'd58000, cm, bcd, oor, lat);
        check("midreset refill cm", cm, 20);
        check("midreset refill bcd", bcd, 'h020);
        measure(24'd870000, cm, bcd, oor, lat);
        check("midreset history", cm, 20);

        // Randomized measurements against the reference model.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            c = 24'($urandom_range(0, 1300000));
            if ($urandom_range(0, 9) == 0)
                c = 24'hFFFFFF;
            model(c, ecm, eoor);
            measure(c, cm, bcd, oor, lat);
            check($sformatf("rnd%0d count=%0d latency", i, c), lat, 37);
            check($sformatf("rnd%0d count=%0d dist_cm", i, c), cm, ecm);
            check($sformatf("rnd%0d count=%0d dist_bcd", i, c), bcd, to_bcd(ecm));
            check($sformatf("rnd%0d count=%0d out_of_range", i, c), oor, eoor);
        end
        check("rnd overrun clear", int'(overrun), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
